// File: rtl/adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digit counter width; a single-digit adder still needs one counter bit.
  function automatic int cnt_width(input int ndig);
    return (ndig <= 1) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/full_adder_slice.sv
// Combinational DIGIT-bit ripple built from 1-bit full adders.
module full_adder_slice #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  always_comb begin
    logic c;
    c = ci;
    s = '0;
    for (int i = 0; i < DIGIT; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    co = c;
  end

endmodule

// File: rtl/serial_adder_nbit.sv
// Digit-serial WIDTH-bit adder: DIGIT bits per clock through one ripple slice.
// Valid/ready on both sides: a transfer happens on a rising edge where valid && ready.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN (adds the sub port).
module serial_adder_nbit
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_adder_nbit: WIDTH must be >= 1 and a multiple of DIGIT >= 1");
    end
  endgenerate

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;

  logic [DIGIT-1:0] w_x;
  logic [DIGIT-1:0] w_y;
  logic [DIGIT-1:0] w_s;
  logic             w_co;
  logic [WIDTH-1:0] w_b_in;
  logic             w_c_in;

  // Subtraction is a + ~b + 1, so b is inverted once at accept time.
`ifdef SERIAL_ADDER_SUB_EN
  assign w_b_in = sub ? ~b : b;
  assign w_c_in = sub ? 1'b1 : cin;
`else
  assign w_b_in = b;
  assign w_c_in = cin;
`endif

  always_comb begin
    w_x = '0;
    w_y = '0;
    for (int k = 0; k < NDIG; k++) begin
      if (r_cnt == CW'(k)) begin
        w_x = r_a[k*DIGIT +: DIGIT];
        w_y = r_b[k*DIGIT +: DIGIT];
      end
    end
  end

  full_adder_slice #(.DIGIT(DIGIT)) u_slice (
    .x  (w_x),
    .y  (w_y),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= w_b_in;
            r_carry <= w_c_in;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < NDIG; k++) begin
            if (r_cnt == CW'(k)) r_sum[k*DIGIT +: DIGIT] <= w_s;
          end
          r_carry <= w_co;
          // Leaving RUN on the last digit keeps the counter from wrapping.
          if (r_cnt == CW'(NDIG - 1)) begin
            r_cout  <= w_co;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == RUN) || (r_state == DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule

// File: tb/tb_serial_adder_nbit.sv
// Bench for serial_adder_nbit: three widths/digit sizes against an arithmetic reference model.
module tb_serial_adder_nbit;

  logic       clk;
  logic       rst_n;
  logic       iv    [3];
  logic       ordy  [3];
  logic       cin_s [3];
  logic       sub_s [3];
  logic [7:0] a_s   [3];
  logic [7:0] b_s   [3];
  logic       irdy  [3];
  logic       ov    [3];
  logic       busy_s[3];
  logic       cout_s[3];
  logic [7:0] sum_s [3];

  int n_tests = 0;
  int n_fail  = 0;
  int ndig[3] = '{4, 8, 1};
  logic [8:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_adder_nbit #(.WIDTH(8), .DIGIT(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]),
    .a(a_s[0]), .b(b_s[0]), .cin(cin_s[0]),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_s[0]),
`endif
    .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sum_s[0]), .cout(cout_s[0]), .busy(busy_s[0])
  );

  serial_adder_nbit #(.WIDTH(8), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]),
    .a(a_s[1]), .b(b_s[1]), .cin(cin_s[1]),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_s[1]),
`endif
    .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sum_s[1]), .cout(cout_s[1]), .busy(busy_s[1])
  );

  serial_adder_nbit #(.WIDTH(8), .DIGIT(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]),
    .a(a_s[2]), .b(b_s[2]), .cin(cin_s[2]),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub_s[2]),
`endif
    .out_valid(ov[2]), .out_ready(ordy[2]), .sum(sum_s[2]), .cout(cout_s[2]), .busy(busy_s[2])
  );

  // Reference: plain unsigned arithmetic, {cout, sum}.
  function automatic logic [8:0] model(input logic [7:0] aa, input logic [7:0] bb,
                                       input logic ci, input logic sb);
    if (sb) return {1'b0, aa} + {1'b0, ~bb} + 9'd1;
    return {1'b0, aa} + {1'b0, bb} + {8'd0, ci};
  endfunction

  // Drive one transaction with out_ready high; report result and accept-to-valid latency.
  task automatic do_op(input int d, input logic [7:0] aa, input logic [7:0] bb,
                       input logic ci, input logic sb,
                       output logic [8:0] res, output int lat);
    int guard;
    guard = 0;
    while (!irdy[d] && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    a_s[d] = aa; b_s[d] = bb; cin_s[d] = ci; sub_s[d] = sb;
    ordy[d] = 1'b1; iv[d] = 1'b1;
    @(posedge clk); #1;
    iv[d] = 1'b0;
    a_s[d] = 8'($urandom); b_s[d] = 8'($urandom); cin_s[d] = 1'($urandom);
    lat = 0;
    while (!ov[d] && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    res = {cout_s[d], sum_s[d]};
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      n_tests++;
      if ({irdy[d], ov[d], busy_s[d], cout_s[d], sum_s[d]} !== {4'b1000, 8'h00}) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: got rdy=%b vld=%b busy=%b cout=%b sum=%h, want 1 0 0 0 00",
                 d, irdy[d], ov[d], busy_s[d], cout_s[d], sum_s[d]);
      end
    end
  endtask

  task automatic test_directed();
    logic [7:0] ta[3] = '{8'hFF, 8'h3C, 8'h80};
    logic [7:0] tb[3] = '{8'h01, 8'h0F, 8'h80};
    logic       tc[3] = '{1'b0, 1'b1, 1'b1};
    logic [8:0] want[3] = '{9'h100, 9'h04C, 9'h101};
    logic [8:0] res;
    int lat;
    for (int d = 0; d < 3; d++) begin
      do_op(d, ta[d], tb[d], tc[d], 1'b0, res, lat);
      n_tests++;
      if (res !== want[d] || lat != ndig[d]) begin
        n_fail++;
        $display("FAIL directed dut%0d: got {cout,sum}=%h lat=%0d, want %h lat=%0d",
                 d, res, lat, want[d], ndig[d]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] aa, bb;
    logic ci;
    logic [8:0] res;
    int lat;
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 15; i++) begin
        aa = 8'($urandom); bb = 8'($urandom); ci = 1'($urandom_range(0, 1));
        if (i == 0) begin aa = 8'hFF; bb = 8'hFF; ci = 1'b1; end
        if (i == 1) begin aa = 8'h00; bb = 8'h00; ci = 1'b0; end
        do_op(d, aa, bb, ci, 1'b0, res, lat);
        n_tests++;
        if (res !== model(aa, bb, ci, 1'b0) || lat != ndig[d]) begin
          n_fail++;
          $display("FAIL random_add dut%0d %h+%h+%b: got %h lat=%0d, want %h lat=%0d",
                   d, aa, bb, ci, res, lat, model(aa, bb, ci, 1'b0), ndig[d]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [8:0] want;
    int lat;
    a_s[0] = 8'h5A; b_s[0] = 8'hC3; cin_s[0] = 1'b1; sub_s[0] = 1'b0;
    want = model(8'h5A, 8'hC3, 1'b1, 1'b0);
    ordy[0] = 1'b0; iv[0] = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!ov[0] && lat < 100) begin
      a_s[0] = 8'($urandom); b_s[0] = 8'($urandom);
      @(posedge clk); #1; lat++;
    end
    n_tests++;
    if ({cout_s[0], sum_s[0]} !== want || lat != 4) begin
      n_fail++;
      $display("FAIL bp_result: got %h lat=%0d, want %h lat=4", {cout_s[0], sum_s[0]}, lat, want);
    end
    for (int i = 0; i < 10; i++) begin
      a_s[0] = 8'($urandom); b_s[0] = 8'($urandom); cin_s[0] = 1'($urandom);
      @(posedge clk); #1;
      n_tests++;
      if ({cout_s[0], sum_s[0]} !== want || irdy[0] !== 1'b0 || ov[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold cyc%0d: got %h rdy=%b vld=%b, want %h rdy=0 vld=1",
                 i, {cout_s[0], sum_s[0]}, irdy[0], ov[0], want);
      end
    end
    a_s[0] = 8'h21; b_s[0] = 8'h42; cin_s[0] = 1'b0; ordy[0] = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (ov[0] !== 1'b0 || irdy[0] !== 1'b1 || {cout_s[0], sum_s[0]} !== want) begin
      n_fail++;
      $display("FAIL bp_release: got vld=%b rdy=%b res=%h, want vld=0 rdy=1 res=%h",
               ov[0], irdy[0], {cout_s[0], sum_s[0]}, want);
    end
    @(posedge clk); #1;
    iv[0] = 1'b0;
    lat = 0;
    while (!ov[0] && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    n_tests++;
    if ({cout_s[0], sum_s[0]} !== 9'h063 || lat != 4) begin
      n_fail++;
      $display("FAIL bp_next_op: got %h lat=%0d, want 063 lat=4", {cout_s[0], sum_s[0]}, lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop();
    logic [8:0] res;
    int lat;
    a_s[0] = 8'hFF; b_s[0] = 8'hFF; cin_s[0] = 1'b1; sub_s[0] = 1'b0;
    ordy[0] = 1'b1; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({irdy[0], ov[0], busy_s[0], cout_s[0], sum_s[0]} !== {4'b1000, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_midop: got rdy=%b vld=%b busy=%b cout=%b sum=%h, want 1 0 0 0 00",
               irdy[0], ov[0], busy_s[0], cout_s[0], sum_s[0]);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op(0, 8'h10, 8'h20, 1'b0, 1'b0, res, lat);
    n_tests++;
    if (res !== 9'h030 || lat != 4) begin
      n_fail++;
      $display("FAIL after_reset_op: got %h lat=%0d, want 030 lat=4", res, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] aa, bb;
    logic ci, acc;
    logic [8:0] want;
    int cyc, last, accepts, results;
    exp_q.delete();
    cyc = 0; last = -1; accepts = 0; results = 0;
    aa = 8'($urandom); bb = 8'($urandom); ci = 1'($urandom);
    a_s[0] = aa; b_s[0] = bb; cin_s[0] = ci; sub_s[0] = 1'b0;
    ordy[0] = 1'b1; iv[0] = 1'b1;
    while (results < 4 && cyc < 200) begin
      acc = iv[0] && irdy[0];
      @(posedge clk); #1; cyc++;
      if (acc) begin
        exp_q.push_back(model(aa, bb, ci, 1'b0));
        if (last >= 0) begin
          n_tests++;
          if (cyc - last != 6) begin
            n_fail++;
            $display("FAIL b2b_period: got %0d cycles, want 6", cyc - last);
          end
        end
        last = cyc;
        accepts++;
        aa = 8'($urandom); bb = 8'($urandom); ci = 1'($urandom);
        a_s[0] = aa; b_s[0] = bb; cin_s[0] = ci;
        if (accepts == 4) iv[0] = 1'b0;
      end
      if (ov[0]) begin
        results++;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1XX;
        n_tests++;
        if ({cout_s[0], sum_s[0]} !== want) begin
          n_fail++;
          $display("FAIL b2b_result%0d: got %h, want %h", results, {cout_s[0], sum_s[0]}, want);
        end
      end
    end
    iv[0] = 1'b0;
    n_tests++;
    if (results != 4) begin
      n_fail++;
      $display("FAIL b2b_timeout: got %0d results, want 4", results);
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub();
    logic [7:0] aa, bb;
    logic [8:0] res;
    int lat;
    do_op(0, 8'h05, 8'h07, 1'b0, 1'b1, res, lat);
    n_tests++;
    if (res !== 9'h0FE) begin
      n_fail++;
      $display("FAIL sub_5_7: got %h, want 0FE", res);
    end
    do_op(0, 8'h07, 8'h05, 1'b1, 1'b1, res, lat);
    n_tests++;
    if (res !== 9'h102) begin
      n_fail++;
      $display("FAIL sub_7_5: got %h, want 102", res);
    end
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 5; i++) begin
        aa = 8'($urandom); bb = 8'($urandom);
        do_op(d, aa, bb, 1'($urandom), 1'b1, res, lat);
        n_tests++;
        if (res !== model(aa, bb, 1'b0, 1'b1) || res[8] !== (aa >= bb)) begin
          n_fail++;
          $display("FAIL random_sub dut%0d %h-%h: got %h, want %h", d, aa, bb, res,
                   model(aa, bb, 1'b0, 1'b1));
        end
      end
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b1; cin_s[d] = 1'b0; sub_s[d] = 1'b0;
      a_s[d] = 8'h00; b_s[d] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_directed();
    test_random();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
